// File: rtl/phase_frame_decoder.sv
// phase_frame_decoder
//   Pulls bytes from the RX FIFO, frames them into checksummed phase packets
//   (SOF, CMD, LEN, payload, CSUM), stages phases in a shadow bank and commits
//   the whole bank to the active outputs in one cycle.
//
// Ports
//   clk           system clock (sys_clk domain)
//   rst_n         asynchronous active-low reset
//   rxfifo_empty  RX FIFO empty flag
//   rxfifo_data   RX FIFO read data
//   rxfifo_valid  read data valid, one cycle after rxfifo_rd
//   rxfifo_rd     RX FIFO read strobe
//   phases        active phase per channel, channel k at [k*PHASE_W +: PHASE_W]
//   commit        one-cycle pulse on the cycle phases updates
//   frame_error   one-cycle pulse on any rejected frame
//   err_cnt       saturating count of rejected frames
//
// state     | meaning
// ----------+--------------------------------------------------
// S_HUNT    | discard bytes until SOF
// S_CMD     | expect command code
// S_LEN     | expect payload length for the latched command
// S_PAYLOAD | write payload bytes into the shadow bank
// S_CSUM    | compare checksum, commit if the command asks for it
module phase_frame_decoder #(
   parameter int          NUM_CHANNELS   = 4,
   parameter int          PHASE_W        = 8,
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter int          ERR_CNT_W      = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            rxfifo_empty,
   input  logic [7:0]                      rxfifo_data,
   input  logic                            rxfifo_valid,
   output logic                            rxfifo_rd,
   output logic [NUM_CHANNELS*PHASE_W-1:0] phases,
   output logic                            commit,
   output logic                            frame_error,
   output logic [ERR_CNT_W-1:0]            err_cnt
);

   localparam int         IDX_W      = $clog2(NUM_CHANNELS + 1);
   localparam int         TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] CMD_SET    = 8'h01;
   localparam logic [7:0] CMD_COMMIT = 8'h02;
   localparam logic [7:0] CMD_SETCOM = 8'h03;
   localparam logic [7:0] LEN_FULL   = 8'(NUM_CHANNELS);

   typedef enum logic [2:0] {
      S_HUNT,
      S_CMD,
      S_LEN,
      S_PAYLOAD,
      S_CSUM
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic                 pending_q;
   logic                 byte_ok;
   logic                 err_evt;
   logic                 commit_evt;
   logic [7:0]           cmd_q;
   logic [7:0]           csum_q;
   logic [IDX_W-1:0]     idx_q;
   logic [TMO_W-1:0]     tmo_q;
   logic [PHASE_W-1:0]   shadow_q [NUM_CHANNELS];
   logic [PHASE_W-1:0]   phases_q [NUM_CHANNELS];

   // A byte only counts when it answers our own outstanding read.
   assign byte_ok = rxfifo_valid && pending_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_HUNT;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      err_evt    = 1'b0;
      commit_evt = 1'b0;
      if (byte_ok) begin
         case (state_q)
            S_HUNT: begin
               if (rxfifo_data == SOF_BYTE) state_nxt = S_CMD;
            end
            S_CMD: begin
               if (rxfifo_data == CMD_SET || rxfifo_data == CMD_COMMIT ||
                   rxfifo_data == CMD_SETCOM) begin
                  state_nxt = S_LEN;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = S_HUNT;
               end
            end
            S_LEN: begin
               if (cmd_q == CMD_COMMIT) begin
                  if (rxfifo_data == 8'h00) begin
                     state_nxt = S_CSUM;
                  end else begin
                     err_evt   = 1'b1;
                     state_nxt = S_HUNT;
                  end
               end else if (rxfifo_data == LEN_FULL) begin
                  state_nxt = S_PAYLOAD;
               end else begin
                  err_evt   = 1'b1;
                  state_nxt = S_HUNT;
               end
            end
            S_PAYLOAD: begin
               if (idx_q == IDX_W'(NUM_CHANNELS - 1)) state_nxt = S_CSUM;
            end
            S_CSUM: begin
               state_nxt = S_HUNT;
               if (csum_q == rxfifo_data) begin
                  commit_evt = (cmd_q != CMD_SET);
               end else begin
                  err_evt = 1'b1;
               end
            end
            default: state_nxt = S_HUNT;
         endcase
      end else if (state_q != S_HUNT && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
         // Stalled frame; a byte arriving on this same cycle takes priority above.
         err_evt   = 1'b1;
         state_nxt = S_HUNT;
      end
   end

   always_comb begin
      rxfifo_rd = !rxfifo_empty && !pending_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= 1'b0;
         cmd_q       <= '0;
         csum_q      <= '0;
         idx_q       <= '0;
         tmo_q       <= '0;
         shadow_q    <= '{default: '0};
         phases_q    <= '{default: '0};
         commit      <= 1'b0;
         frame_error <= 1'b0;
         err_cnt     <= '0;
      end else begin
         commit      <= commit_evt;
         frame_error <= err_evt;
         if (err_evt && err_cnt != '1) err_cnt <= err_cnt + 1'b1;

         if (byte_ok) begin
            pending_q <= 1'b0;
         end else if (rxfifo_rd) begin
            pending_q <= 1'b1;
         end

         tmo_q <= (byte_ok || state_nxt == S_HUNT) ? '0 : tmo_q + 1'b1;

         if (byte_ok) begin
            case (state_q)
               S_CMD: begin
                  cmd_q  <= rxfifo_data;
                  csum_q <= rxfifo_data;
               end
               S_LEN: begin
                  csum_q <= csum_q ^ rxfifo_data;
                  idx_q  <= '0;
               end
               S_PAYLOAD: begin
                  shadow_q[idx_q] <= rxfifo_data[PHASE_W-1:0];
                  csum_q          <= csum_q ^ rxfifo_data;
                  idx_q           <= idx_q + 1'b1;
               end
               default: ;
            endcase
         end

         // Shadow already holds this frame's payload by the CSUM byte.
         if (commit_evt) phases_q <= shadow_q;
      end
   end

   for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_phase_out
      assign phases[g*PHASE_W +: PHASE_W] = phases_q[g];
   end

endmodule

// File: tb/tb_phase_frame_decoder.sv
module tb_phase_frame_decoder;
   localparam int NCH  = 4;
   localparam int PW   = 8;
   localparam int TMO  = 1024;
   localparam int EW   = 8;
   localparam int EMAX = (1 << EW) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              rxfifo_empty = 1'b1;
   logic [7:0]        rxfifo_data = 8'h00;
   logic              rxfifo_valid = 1'b0;
   logic              rxfifo_rd;
   logic [NCH*PW-1:0] phases;
   logic              commit;
   logic              frame_error;
   logic [EW-1:0]     err_cnt;

   phase_frame_decoder #(
      .NUM_CHANNELS(NCH), .PHASE_W(PW), .SOF_BYTE(8'hA5),
      .TIMEOUT_CYCLES(TMO), .ERR_CNT_W(EW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rxfifo_empty(rxfifo_empty),
      .rxfifo_data(rxfifo_data), .rxfifo_valid(rxfifo_valid),
      .rxfifo_rd(rxfifo_rd), .phases(phases), .commit(commit),
      .frame_error(frame_error), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures < 40) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- FIFO model: one read outstanding, data one cycle later
   logic [7:0] fifo_q[$];
   bit rd_latched = 0;
   bit outstanding = 0;
   bit inject_spur = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         rxfifo_valid = 1'b0;
         outstanding  = 0;
         rd_latched   = 0;
         rxfifo_empty = (fifo_q.size() == 0);
      end else begin
         if (rxfifo_valid) outstanding = 0;
         rxfifo_valid = 1'b0;
         if (rd_latched) begin
            rxfifo_valid = 1'b1;
            rxfifo_data  = fifo_q.pop_front();
         end else if (inject_spur && !outstanding) begin
            rxfifo_valid = 1'b1;
            rxfifo_data  = 8'hA5;
         end
         rxfifo_empty = (fifo_q.size() == 0);
         #1;
         if (rst_n) begin
            chk("rd_handshake", 64'(rxfifo_rd), 64'(!rxfifo_empty && !outstanding));
            rd_latched = rxfifo_rd;
            if (rd_latched) outstanding = 1;
         end
      end
   end

   // ---------------- Frame-level reference model
   logic [7:0] frm[$];
   logic [7:0] m_sh[NCH];
   logic [7:0] m_ph[NCH];
   bit m_commit = 0;
   bit m_err = 0;
   int m_errcnt = 0;
   int idle = 0;

   initial begin
      for (int i = 0; i < NCH; i++) begin
         m_sh[i] = 8'h00;
         m_ph[i] = 8'h00;
      end
   end

   function automatic void m_reject();
      m_err = 1;
      if (m_errcnt < EMAX) m_errcnt++;
      frm.delete();
   endfunction

   function automatic void m_byte(input logic [7:0] b);
      int n;
      int len;
      logic [7:0] x;
      logic [7:0] el;
      if (frm.size() == 0) begin
         if (b == 8'hA5) frm.push_back(b);
         return;
      end
      frm.push_back(b);
      n = frm.size();
      if (n == 2) begin
         if (!(b inside {8'h01, 8'h02, 8'h03})) m_reject();
      end else if (n == 3) begin
         el = (frm[1] == 8'h02) ? 8'h00 : 8'(NCH);
         if (b != el) m_reject();
      end else begin
         len = int'(frm[2]);
         if (n <= len + 3) begin
            m_sh[n-4] = b;
         end else begin
            x = 8'h00;
            for (int i = 1; i < n - 1; i++) x ^= frm[i];
            if (x != b) begin
               m_reject();
            end else begin
               if (frm[1] != 8'h01) begin
                  m_ph = m_sh;
                  m_commit = 1;
               end
               frm.delete();
            end
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm.delete();
         for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 8'h00;
            m_ph[i] = 8'h00;
         end
         m_commit = 0;
         m_err    = 0;
         m_errcnt = 0;
         idle     = 0;
      end else begin
         m_commit = 0;
         m_err    = 0;
         if (rxfifo_valid && outstanding) begin
            idle = 0;
            m_byte(rxfifo_data);
         end else if (frm.size() != 0) begin
            idle++;
            if (idle == TMO) m_reject();
         end
      end
   end

   // ---------------- Per-cycle compare and pulse counters
   int n_commit = 0;
   int n_err = 0;

   always @(negedge clk) begin
      logic [NCH*PW-1:0] e;
      if (rst_n) begin
         for (int i = 0; i < NCH; i++) e[i*PW +: PW] = m_ph[i];
         chk("phases", 64'(phases), 64'(e));
         chk("commit", 64'(commit), 64'(m_commit));
         chk("frame_error", 64'(frame_error), 64'(m_err));
         chk("err_cnt", 64'(err_cnt), 64'(m_errcnt));
         if (commit) n_commit++;
         if (frame_error) n_err++;
      end
   end

   // ---------------- Stimulus helpers
   task automatic push_frame(input logic [7:0] cmd, input logic [7:0] len,
                             input logic [31:0] pay, input int npay, input logic [7:0] bad);
      logic [7:0] cs;
      logic [7:0] pb;
      cs = cmd ^ len;
      fifo_q.push_back(8'hA5);
      fifo_q.push_back(cmd);
      fifo_q.push_back(len);
      for (int k = 0; k < npay; k++) begin
         pb = pay[k*8 +: 8];
         fifo_q.push_back(pb);
         cs ^= pb;
      end
      fifo_q.push_back(cs ^ bad);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || outstanding || rxfifo_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_bound", 64'(n < 5000), 64'(1));
      repeat (3) @(negedge clk);
   endtask

   task automatic clr_counts();
      n_commit = 0;
      n_err = 0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_phases", 64'(phases), 64'(0));
      chk("rst_commit", 64'(commit), 64'(0));
      chk("rst_ferr", 64'(frame_error), 64'(0));
      chk("rst_errcnt", 64'(err_cnt), 64'(0));
      chk("rst_rd", 64'(rxfifo_rd), 64'(0));
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // SET_COMMIT
      clr_counts();
      push_frame(8'h03, 8'h04, 32'h40302010, 4, 8'h00);
      drain();
      chk("t1_phases", 64'(phases), 64'h40302010);
      chk("t1_commits", 64'(n_commit), 64'(1));
      chk("t1_errcnt", 64'(err_cnt), 64'(0));

      // SET then COMMIT
      clr_counts();
      push_frame(8'h01, 8'h04, 32'h04030201, 4, 8'h00);
      drain();
      chk("t2_set_phases", 64'(phases), 64'h40302010);
      chk("t2_set_commits", 64'(n_commit), 64'(0));
      push_frame(8'h02, 8'h00, 32'h0, 0, 8'h00);
      drain();
      chk("t2_com_phases", 64'(phases), 64'h04030201);
      chk("t2_com_commits", 64'(n_commit), 64'(1));

      // Bad checksum then resend
      clr_counts();
      push_frame(8'h03, 8'h04, 32'h40302010, 4, 8'hFF);
      drain();
      chk("t3_err_pulses", 64'(n_err), 64'(1));
      chk("t3_errcnt", 64'(err_cnt), 64'(1));
      chk("t3_phases", 64'(phases), 64'h04030201);
      push_frame(8'h03, 8'h04, 32'h40302010, 4, 8'h00);
      drain();
      chk("t3_resend_phases", 64'(phases), 64'h40302010);

      // Garbage before a frame, then LEN error
      clr_counts();
      fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h5A);
      push_frame(8'h03, 8'h04, 32'h0D0C0B0A, 4, 8'h00);
      drain();
      chk("t4_garbage_err", 64'(n_err), 64'(0));
      chk("t4_phases", 64'(phases), 64'h0D0C0B0A);
      fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01); fifo_q.push_back(8'h03);
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
      drain();
      chk("t4_len_err", 64'(n_err), 64'(1));
      chk("t4_len_errcnt", 64'(err_cnt), 64'(2));

      // Rejecting byte equal to SOF is not re-examined
      clr_counts();
      fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01); fifo_q.push_back(8'hA5);
      fifo_q.push_back(8'h02); fifo_q.push_back(8'h00); fifo_q.push_back(8'h02);
      drain();
      chk("t5_sof_err", 64'(n_err), 64'(1));
      chk("t5_sof_commits", 64'(n_commit), 64'(0));
      chk("t5_errcnt", 64'(err_cnt), 64'(3));

      // Unsolicited valid is ignored
      clr_counts();
      inject_spur = 1;
      repeat (6) @(negedge clk);
      inject_spur = 0;
      repeat (2) @(negedge clk);
      fifo_q.push_back(8'h02); fifo_q.push_back(8'h00); fifo_q.push_back(8'h02);
      drain();
      chk("t6_spur_commits", 64'(n_commit), 64'(0));
      chk("t6_spur_err", 64'(n_err), 64'(0));

      // Stalled frame timeout
      clr_counts();
      fifo_q.push_back(8'hA5); fifo_q.push_back(8'h01); fifo_q.push_back(8'h04);
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
      drain();
      repeat (TMO + 20) @(negedge clk);
      chk("t7_tmo_pulses", 64'(n_err), 64'(1));
      chk("t7_tmo_errcnt", 64'(err_cnt), 64'(4));
      push_frame(8'h03, 8'h04, 32'h44332211, 4, 8'h00);
      drain();
      chk("t7_after_phases", 64'(phases), 64'h44332211);
      chk("t7_after_pulses", 64'(n_err), 64'(1));

      // Bytes arriving around the timeout boundary
      for (int d = TMO - 10; d <= TMO; d++) begin
         fifo_q.push_back(8'hA5);
         drain();
         repeat (d) @(negedge clk);
         fifo_q.push_back(8'h02); fifo_q.push_back(8'h00); fifo_q.push_back(8'h02);
         drain();
      end

      // Error counter saturation
      for (int i = 0; i < 300; i++) begin
         fifo_q.push_back(8'hA5);
         fifo_q.push_back(8'h07);
      end
      drain();
      chk("t8_saturate", 64'(err_cnt), 64'(EMAX));

      // Reset mid-payload
      push_frame(8'h03, 8'h04, 32'h40302010, 4, 8'h00);
      repeat (9) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("t9_rst_phases", 64'(phases), 64'(0));
      chk("t9_rst_errcnt", 64'(err_cnt), 64'(0));
      chk("t9_rst_commit", 64'(commit), 64'(0));
      chk("t9_rst_ferr", 64'(frame_error), 64'(0));
      fifo_q.delete();
      repeat (2) @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      clr_counts();
      push_frame(8'h03, 8'h04, 32'h08070605, 4, 8'h00);
      drain();
      chk("t9_after_phases", 64'(phases), 64'h08070605);
      chk("t9_after_errcnt", 64'(err_cnt), 64'(0));
      chk("t9_after_commits", 64'(n_commit), 64'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
